// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four BCD digits with a run / pause / adjust state machine.
// Counts on en_1hz in RUN, steps the selected field on en_2hz in ADJUST.
module stopwatch_counter #(
  parameter int MIN_MAX       = 99,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       en_2hz,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       adjusting,
  output logic       wrap
);

  localparam logic [3:0] MAX_T   = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O   = 4'(MIN_MAX % 10);
  localparam logic [7:0] MAX_BCD = {MAX_T, MAX_O};

  typedef enum logic [1:0] {
    S_PAUSED = 2'd0,
    S_RUN    = 2'd1,
    S_ADJUST = 2'd2
  } state_e;

  localparam state_e RST_STATE = START_RUNNING ? S_RUN : S_PAUSED;

  state_e     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       wrap_q, wrap_d;

  // Seconds field as {tens, ones}: 59 rolls to 00.
  function automatic logic [7:0] inc_sec(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (s[7:4] >= 4'd5) ? 4'd0 : s[7:4] + 4'd1;
    end else begin
      r[3:0] = s[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Minutes field as {tens, ones}: MIN_MAX (or anything beyond) rolls to 00.
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    logic [7:0] r;
    r = m;
    if ((m[7:4] > MAX_T) || ((m[7:4] == MAX_T) && (m[3:0] >= MAX_O))) begin
      r = 8'h00;
    end else if (m[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = m[7:4] + 4'd1;
    end else begin
      r[3:0] = m[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    wrap_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        // A tick coinciding with pause_p is still counted.
        if (en_1hz) begin
          sec_d = inc_sec(sec_q);
          if (sec_q == 8'h59) begin
            min_d  = inc_min(min_q);
            wrap_d = (min_q == MAX_BCD);
          end
        end
        if (adj)          state_d = S_ADJUST;
        else if (pause_p) state_d = S_PAUSED;
      end
      S_ADJUST: begin
        if (en_2hz) begin
          if (sel) sec_d = inc_sec(sec_q);
          else     min_d = inc_min(min_q);
        end
        if (!adj) state_d = S_PAUSED;
      end
      default: begin
        if (adj)          state_d = S_ADJUST;
        else if (pause_p) state_d = S_RUN;
      end
    endcase
    // Clear overrides any tick or step on the same edge.
    if (clr_p) begin
      sec_d  = 8'h00;
      min_d  = 8'h00;
      wrap_d = 1'b0;
    end
  end

  assign min_tens  = min_q[7:4];
  assign min_ones  = min_q[3:0];
  assign sec_tens  = sec_q[7:4];
  assign sec_ones  = sec_q[3:0];
  assign running   = (state_q == S_RUN);
  assign adjusting = (state_q == S_ADJUST);
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter: two builds (MIN_MAX=99 and 59) share stimulus;
// directed steps push hand-computed expectations, a negedge monitor pops and compares.
module tb_stopwatch_counter;

  logic clk_100mhz = 1'b0;
  logic rst = 1'b1;
  logic en_1hz = 1'b0, en_2hz = 1'b0, pause_p = 1'b0, clr_p = 1'b0, adj = 1'b0, sel = 1'b0;

  logic [3:0] a_mt, a_mo, a_st, a_so, b_mt, b_mo, b_st, b_so;
  logic       a_run, a_adj, a_wrap, b_run, b_adj, b_wrap;

  always #5 clk_100mhz = ~clk_100mhz;

  stopwatch_counter #(.MIN_MAX(99), .START_RUNNING(1'b0)) dut_a (
    .clk_100mhz(clk_100mhz), .rst(rst), .en_1hz(en_1hz), .en_2hz(en_2hz),
    .pause_p(pause_p), .clr_p(clr_p), .adj(adj), .sel(sel),
    .min_tens(a_mt), .min_ones(a_mo), .sec_tens(a_st), .sec_ones(a_so),
    .running(a_run), .adjusting(a_adj), .wrap(a_wrap)
  );

  stopwatch_counter #(.MIN_MAX(59), .START_RUNNING(1'b0)) dut_b (
    .clk_100mhz(clk_100mhz), .rst(rst), .en_1hz(en_1hz), .en_2hz(en_2hz),
    .pause_p(pause_p), .clr_p(clr_p), .adj(adj), .sel(sel),
    .min_tens(b_mt), .min_ones(b_mo), .sec_tens(b_st), .sec_ones(b_so),
    .running(b_run), .adjusting(b_adj), .wrap(b_wrap)
  );

  typedef struct {
    string       name;
    int          which;   // 0 = MIN_MAX 99 build, 1 = MIN_MAX 59 build
    logic [15:0] dig;     // {min_tens, min_ones, sec_tens, sec_ones}
    logic        run;
    logic        adjg;
    logic        wrp;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always @(negedge clk_100mhz) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [15:0] d;
      logic        r, ad, w;
      e = exp_q.pop_front();
      if (e.which == 0) begin
        d = {a_mt, a_mo, a_st, a_so}; r = a_run; ad = a_adj; w = a_wrap;
      end else begin
        d = {b_mt, b_mo, b_st, b_so}; r = b_run; ad = b_adj; w = b_wrap;
      end
      vectors++;
      if (d !== e.dig || r !== e.run || ad !== e.adjg || w !== e.wrp) begin
        miscompares++;
        $display("FAIL %s (dut %0d): got %h run=%b adj=%b wrap=%b, expected %h run=%b adj=%b wrap=%b",
                 e.name, e.which, d, r, ad, w, e.dig, e.run, e.adjg, e.wrp);
      end
    end
  end

  task automatic cyc(input logic e1, input logic e2, input logic p, input logic c);
    en_1hz = e1; en_2hz = e2; pause_p = p; clr_p = c;
    @(posedge clk_100mhz);
    #1;
    en_1hz = 1'b0; en_2hz = 1'b0; pause_p = 1'b0; clr_p = 1'b0;
  endtask

  task automatic steps2(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_st(input string n, input int w, input logic [15:0] d,
                           input logic r, input logic a, input logic wr);
    exp_t e;
    e.name = n; e.which = w; e.dig = d; e.run = r; e.adjg = a; e.wrp = wr;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_100mhz);
    #1;
    expect_st("reset_a", 0, 16'h0000, 0, 0, 0);
    expect_st("reset_b", 1, 16'h0000, 0, 0, 0);
    rst = 1'b0;

    // Paused after reset: ticks ignored until pause_p.
    repeat (3) cyc(1, 0, 0, 0);
    expect_st("paused_ignores_tick", 0, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0);
    expect_st("resume", 0, 16'h0000, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    expect_st("count3", 0, 16'h0003, 1, 0, 0);

    // 00:59 -> 01:00 without wrap.
    cyc(0, 0, 0, 1);
    expect_st("clear_in_run", 0, 16'h0000, 1, 0, 0);
    adj = 1; sel = 1;
    cyc(0, 0, 0, 0);
    expect_st("enter_adjust", 0, 16'h0000, 0, 1, 0);
    steps2(59);
    expect_st("adj_sec_59", 0, 16'h0059, 0, 1, 0);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    expect_st("run_at_0059", 0, 16'h0059, 1, 0, 0);
    cyc(1, 0, 0, 0);
    expect_st("sec_carry_min", 0, 16'h0100, 1, 0, 0);

    // 99:59 -> 00:00 with single-cycle wrap.
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0);
    steps2(98);
    sel = 1;
    steps2(59);
    expect_st("preload_9959", 0, 16'h9959, 0, 1, 0);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    expect_st("full_wrap", 0, 16'h0000, 1, 0, 1);
    cyc(0, 0, 0, 0);
    expect_st("wrap_one_cycle", 0, 16'h0000, 1, 0, 0);

    // Adjust seconds roll without carry, minutes roll, ignored strobes.
    adj = 1; sel = 1;
    cyc(0, 0, 0, 0);
    steps2(58);
    expect_st("adj_sec_58", 0, 16'h0058, 0, 1, 0);
    steps2(2);
    expect_st("adj_sec_roll", 0, 16'h0000, 0, 1, 0);
    steps2(5);
    sel = 0;
    steps2(99);
    expect_st("adj_min_99", 0, 16'h9905, 0, 1, 0);
    steps2(1);
    expect_st("adj_min_roll", 0, 16'h0005, 0, 1, 0);
    cyc(1, 0, 0, 0);
    expect_st("adj_ignores_1hz", 0, 16'h0005, 0, 1, 0);
    sel = 1;
    cyc(0, 1, 0, 0);
    expect_st("sel_same_edge", 0, 16'h0006, 0, 1, 0);
    cyc(0, 0, 1, 0);
    expect_st("adj_ignores_pause", 0, 16'h0006, 0, 1, 0);
    adj = 0;
    cyc(0, 0, 0, 0);
    expect_st("adj_exit_paused", 0, 16'h0006, 0, 0, 0);

    // Tick plus pause on the same edge at 00:10.
    adj = 1; sel = 1;
    cyc(0, 0, 0, 0);
    steps2(4);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    expect_st("run_at_0010", 0, 16'h0010, 1, 0, 0);
    cyc(1, 0, 1, 0);
    expect_st("tick_and_pause", 0, 16'h0011, 0, 0, 0);

    // Clear beats tick at 12:34.
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0);
    steps2(12);
    sel = 1;
    steps2(23);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    expect_st("run_at_1234", 0, 16'h1234, 1, 0, 0);
    cyc(1, 0, 0, 1);
    expect_st("clr_beats_tick", 0, 16'h0000, 1, 0, 0);

    // Asynchronous reset between edges at 05:07.
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0);
    steps2(5);
    sel = 1;
    steps2(7);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    expect_st("run_at_0507", 0, 16'h0507, 1, 0, 0);
    cyc(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    expect_st("async_rst_a", 0, 16'h0000, 0, 0, 0);
    expect_st("async_rst_b", 1, 16'h0000, 0, 0, 0);
    @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
    repeat (3) cyc(1, 0, 0, 0);
    expect_st("post_rst_paused", 0, 16'h0000, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    expect_st("post_rst_count", 0, 16'h0001, 1, 0, 0);

    // MIN_MAX=59 build wraps at 59:59; the 99 build goes on to 60:00.
    cyc(0, 0, 0, 1);
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0);
    steps2(59);
    sel = 1;
    steps2(59);
    expect_st("b_preload_5959", 1, 16'h5959, 0, 1, 0);
    adj = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    expect_st("b_full_wrap", 1, 16'h0000, 1, 0, 1);
    expect_st("a_no_wrap_at_59", 0, 16'h6000, 1, 0, 0);
    cyc(0, 0, 0, 0);
    expect_st("b_wrap_one_cycle", 1, 16'h0000, 1, 0, 0);

    // MIN_MAX=59 adjust minutes 59 -> 00.
    cyc(0, 0, 0, 1);
    adj = 1; sel = 0;
    cyc(0, 0, 0, 0);
    steps2(59);
    expect_st("b_adj_min_59", 1, 16'h5900, 0, 1, 0);
    steps2(1);
    expect_st("b_adj_min_roll", 1, 16'h0000, 0, 1, 0);
    expect_st("a_adj_min_60", 0, 16'h6000, 0, 1, 0);

    repeat (3) @(negedge clk_100mhz);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
